// File: rtl/vm_input_conditioner_if.sv
// vm_input_conditioner_if
//   Groups the raw vending-machine inputs and the conditioned outputs of the
//   input conditioner into one bundle.
//   master : drives the raw switches/buttons, observes the conditioned stream
//   slave  : the conditioner itself
//   Signals:
//     switch[3:0]        raw coin switches ([0]=1, [1]=5, [2]=10, [3]=20 units)
//     L/R/C_button       raw select/confirm buttons (asynchronous)
//     switch_level[3:0]  debounced switch levels
//     coin_valid         one-cycle strobe, one coin accepted
//     coin_value[4:0]    value of the accepted coin, 0 when coin_valid=0
//     l/r/c_pulse        one-cycle pulses on debounced button presses
//     coin_drop          sticky flag: a coin edge was lost
interface vm_input_conditioner_if;
  logic [3:0] switch;
  logic       L_button;
  logic       R_button;
  logic       C_button;
  logic [3:0] switch_level;
  logic       coin_valid;
  logic [4:0] coin_value;
  logic       l_pulse;
  logic       r_pulse;
  logic       c_pulse;
  logic       coin_drop;

  modport master (
    output switch, L_button, R_button, C_button,
    input  switch_level, coin_valid, coin_value, l_pulse, r_pulse, c_pulse, coin_drop
  );

  modport slave (
    input  switch, L_button, R_button, C_button,
    output switch_level, coin_valid, coin_value, l_pulse, r_pulse, c_pulse, coin_drop
  );
endinterface

// File: rtl/vm_input_conditioner.sv
// vm_input_conditioner
//   Front end of the vending machine. Every raw input (4 coin switches and the
//   L/R/C buttons) is 2-flop synchronised, debounced, and rising-edge detected.
//   Buttons become single-cycle pulses; coin rises are serialised into one
//   coin_valid/coin_value stream, lowest switch index first.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  vm_input_conditioner_if.slave (raw inputs in, conditioned outputs out)
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive differing samples needed to accept a change (>=2)
//     CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
module vm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input logic                    clk,
  input logic                    rst,
  vm_input_conditioner_if.slave  bus
);

  localparam int              N_IN     = 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order: [3:0] coin switches, [4] L, [5] R, [6] C.
  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] rise;
  logic [3:0]      sw_level;

  assign raw = {bus.C_button, bus.R_button, bus.L_button, bus.switch};

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_deb
      logic             s1_reg;
      logic             s2_reg;
      logic             stable_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             flip;

      // The counter only ever advances while s2 differs from the accepted
      // level, so reaching CNT_LAST with s2 still differing means
      // DEBOUNCE_CYCLES consecutive differing samples.
      assign flip     = (s2_reg != stable_reg) && (cnt_reg == CNT_LAST);
      assign rise[gi] = flip & s2_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg     <= 1'b0;
          s2_reg     <= 1'b0;
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (flip) begin
            stable_reg <= s2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      if (gi < 4) begin : g_lvl
        assign sw_level[gi] = stable_reg;
      end
    end
  endgenerate

  // Coin serialiser: new rises merge with coins still waiting, and the
  // lowest-index coin goes out this edge.
  logic [3:0] pend_reg;
  logic [3:0] pend_all;
  logic [3:0] pick;
  logic [3:0] pend_next;
  logic [4:0] val_pick;
  logic       lost;

  always_comb begin
    pend_all  = pend_reg | rise[3:0];
    pick      = pend_all & (~pend_all + 4'd1);  // isolate lowest set bit
    pend_next = pend_all & ~pick;
    lost      = |(pend_reg & rise[3:0]);
    val_pick  = 5'd0;
    case (pick)
      4'b0001: val_pick = 5'd1;
      4'b0010: val_pick = 5'd5;
      4'b0100: val_pick = 5'd10;
      4'b1000: val_pick = 5'd20;
      default: val_pick = 5'd0;
    endcase
  end

  logic       coin_valid_reg;
  logic [4:0] coin_value_reg;
  logic       l_pulse_reg;
  logic       r_pulse_reg;
  logic       c_pulse_reg;
  logic       coin_drop_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg       <= 4'd0;
      coin_valid_reg <= 1'b0;
      coin_value_reg <= 5'd0;
      l_pulse_reg    <= 1'b0;
      r_pulse_reg    <= 1'b0;
      c_pulse_reg    <= 1'b0;
      coin_drop_reg  <= 1'b0;
    end else begin
      pend_reg       <= pend_next;
      coin_valid_reg <= |pend_all;
      coin_value_reg <= val_pick;
      // Simultaneous L and R presses are ambiguous, so neither is reported.
      l_pulse_reg    <= rise[4] & ~rise[5];
      r_pulse_reg    <= rise[5] & ~rise[4];
      c_pulse_reg    <= rise[6];
      coin_drop_reg  <= coin_drop_reg | lost;
    end
  end

  assign bus.switch_level = sw_level;
  assign bus.coin_valid   = coin_valid_reg;
  assign bus.coin_value   = coin_value_reg;
  assign bus.l_pulse      = l_pulse_reg;
  assign bus.r_pulse      = r_pulse_reg;
  assign bus.c_pulse      = c_pulse_reg;
  assign bus.coin_drop    = coin_drop_reg;

endmodule

// File: tb/tb_vm_input_conditioner.sv
module tb_vm_input_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vm_input_conditioner_if bus ();

  vm_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int cyc;
    int kind;   // 0 coin, 1 L, 2 R, 3 C
    int val;
  } ev_t;

  ev_t        exp_q[$];
  logic [6:0] hist_q[$];   // raw samples taken at each edge since reset
  bit   [6:0] m_stable;
  bit   [3:0] m_pend;
  bit         m_drop;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         obs_cnt[4] = '{0, 0, 0, 0};
  int         last_coin = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int coin_val(input int j);
    case (j)
      0: return 1;
      1: return 5;
      2: return 10;
      default: return 20;
    endcase
  endfunction

  // Reference model: an input's accepted level changes once the last D
  // synchronised samples (raw delayed by two edges) all disagree with it.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        hist_q.delete();
        m_stable = '0;
        m_pend   = '0;
        m_drop   = 1'b0;
      end else begin
        bit [6:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) begin
          bit all_diff;
          bit s2_now;
          all_diff = 1'b1;
          s2_now   = 1'b0;
          for (int k = 0; k < D; k++) begin
            int idx;
            bit v;
            idx = hist_q.size() - 2 - k;
            v   = (idx >= 0) ? hist_q[idx][i] : 1'b0;
            if (k == 0) s2_now = v;
            if (v == m_stable[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_stable[i] = s2_now;
            r[i]        = s2_now;
          end
        end
        for (int j = 0; j < 4; j++) begin
          if (r[j]) begin
            if (m_pend[j]) m_drop = 1'b1;
            m_pend[j] = 1'b1;
          end
        end
        for (int j = 0; j < 4; j++) begin
          if (m_pend[j]) begin
            exp_q.push_back('{cyc: cyc, kind: 0, val: coin_val(j)});
            m_pend[j] = 1'b0;
            break;
          end
        end
        if (r[4] && !r[5]) exp_q.push_back('{cyc: cyc, kind: 1, val: 1});
        if (r[5] && !r[4]) exp_q.push_back('{cyc: cyc, kind: 2, val: 1});
        if (r[6])          exp_q.push_back('{cyc: cyc, kind: 3, val: 1});
        hist_q.push_back({bus.C_button, bus.R_button, bus.L_button, bus.switch});
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    forever begin
      bit [3:0] a;
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_event: got none, expected kind=%0d val=%0d cyc=%0d",
                 exp_q[0].kind, exp_q[0].val, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      a = {bus.c_pulse === 1'b1, bus.r_pulse === 1'b1, bus.l_pulse === 1'b1, bus.coin_valid === 1'b1};
      for (int k = 0; k < 4; k++) begin
        if (a[k]) begin
          int v;
          v = (k == 0) ? int'(bus.coin_value) : 1;
          obs_cnt[k]++;
          if (k == 0) last_coin = v;
          $display("event cyc=%0d kind=%0d val=%0d", cyc, k, v);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, expected none", k, v, cyc);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || e.cyc != cyc) begin
              bad++;
              $display("FAIL event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                       k, v, cyc, e.kind, e.val, e.cyc);
            end
          end
        end
      end
      if (bus.coin_valid !== 1'b1) check("coin_value_idle", 32'(bus.coin_value), 32'd0);
      check("switch_level", 32'(bus.switch_level), 32'(m_stable[3:0]));
      check("coin_drop", 32'(bus.coin_drop), 32'(m_drop));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base[4];
  task automatic snap();
    for (int k = 0; k < 4; k++) base[k] = obs_cnt[k];
  endtask

  initial begin
    bus.switch   = 4'd0;
    bus.L_button = 1'b0;
    bus.R_button = 1'b0;
    bus.C_button = 1'b0;
    rst = 1'b1;
    cycles(3);
    check("reset_outputs",
          {20'd0, bus.switch_level, bus.coin_valid, bus.coin_value, bus.l_pulse,
           bus.r_pulse, bus.c_pulse, bus.coin_drop}, 32'd0);
    rst = 1'b0;

    // 1: clean step on switch[1]
    snap();
    bus.switch[1] = 1'b1;
    cycles(12);
    check("t1_coin_count", 32'(obs_cnt[0] - base[0]), 32'd1);
    check("t1_coin_value", 32'(last_coin), 32'd5);
    bus.switch[1] = 1'b0;
    cycles(12);

    // 2: short C glitch, then a real press
    snap();
    bus.C_button = 1'b1;
    cycles(3);
    bus.C_button = 1'b0;
    cycles(10);
    check("t2_glitch_c", 32'(obs_cnt[3] - base[3]), 32'd0);
    bus.C_button = 1'b1;
    cycles(10);
    bus.C_button = 1'b0;
    cycles(12);
    check("t2_press_c", 32'(obs_cnt[3] - base[3]), 32'd1);

    // 3: two coins together
    snap();
    bus.switch = 4'b1001;
    cycles(12);
    check("t3_coin_count", 32'(obs_cnt[0] - base[0]), 32'd2);
    check("t3_last_value", 32'(last_coin), 32'd20);
    bus.switch = 4'b0000;
    cycles(12);

    // 4: bouncy L
    snap();
    bus.L_button = 1'b1; cycles(1);
    bus.L_button = 1'b0; cycles(1);
    bus.L_button = 1'b1; cycles(10);
    bus.L_button = 1'b0; cycles(12);
    check("t4_l_once", 32'(obs_cnt[1] - base[1]), 32'd1);

    // 5: L and R together, then R alone
    snap();
    bus.L_button = 1'b1;
    bus.R_button = 1'b1;
    cycles(10);
    bus.L_button = 1'b0;
    bus.R_button = 1'b0;
    cycles(12);
    check("t5_l_suppressed", 32'(obs_cnt[1] - base[1]), 32'd0);
    check("t5_r_suppressed", 32'(obs_cnt[2] - base[2]), 32'd0);
    bus.R_button = 1'b1;
    cycles(10);
    bus.R_button = 1'b0;
    cycles(12);
    check("t5_r_alone", 32'(obs_cnt[2] - base[2]), 32'd1);

    // 6: reset in the middle of a debounce count
    snap();
    bus.switch[2] = 1'b1;
    cycles(4);
    rst = 1'b1;
    cycles(1);
    check("t6_reset_level", 32'(bus.switch_level), 32'd0);
    check("t6_reset_valid", 32'(bus.coin_valid), 32'd0);
    rst = 1'b0;
    cycles(12);
    check("t6_coin_count", 32'(obs_cnt[0] - base[0]), 32'd1);
    check("t6_coin_value", 32'(last_coin), 32'd10);
    bus.switch[2] = 1'b0;
    cycles(12);

    // Random phase: alternating bouncy and calm periods, rare resets.
    for (int ph = 0; ph < 12; ph++) begin
      int lim;
      lim = (ph % 2 == 0) ? 3 : 16;
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(lim - 1) == 0) bus.switch[0] = ~bus.switch[0];
        if ($urandom_range(lim - 1) == 0) bus.switch[1] = ~bus.switch[1];
        if ($urandom_range(lim - 1) == 0) bus.switch[2] = ~bus.switch[2];
        if ($urandom_range(lim - 1) == 0) bus.switch[3] = ~bus.switch[3];
        if ($urandom_range(lim - 1) == 0) bus.L_button = ~bus.L_button;
        if ($urandom_range(lim - 1) == 0) bus.R_button = ~bus.R_button;
        if ($urandom_range(lim - 1) == 0) bus.C_button = ~bus.C_button;
        rst = ($urandom_range(599) == 0);
        cycles(1);
      end
    end
    rst = 1'b0;
    bus.switch   = 4'd0;
    bus.L_button = 1'b0;
    bus.R_button = 1'b0;
    bus.C_button = 1'b0;
    cycles(20);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
